modulo_arbiter: RTL and testbench

- Shares one `modulo` unit (ports go/rst/a/b/ready/error/res) between NREQ requesters, e.g. several prime generators or divisibility checkers.
- Round-robin arbitration.
- Latches the winner's operands and sequences the modulo go/ready handshake, including its one-cycle ready-drop delay.
- Returns the result to the winner with a one-cycle done pulse.
- Sits between the requesters and a single `modulo` instance.

---
 rtl/modulo_arbiter_if.sv | 30 +++
 rtl/modulo_arbiter.sv | 136 +++++++++++++
 tb/tb_modulo_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modulo_arbiter_if.sv
// Requester-side and modulo-side signals of the shared modulo arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the modulo unit.
interface modulo_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a;
    logic [NREQ*WIDTH-1:0] b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      res;
    logic                  err;
    logic                  mod_go;
    logic [WIDTH-1:0]      mod_a;
    logic [WIDTH-1:0]      mod_b;
    logic                  mod_ready;
    logic                  mod_error;
    logic [WIDTH-1:0]      mod_res;

    modport slave (
        input  req, a, b, mod_ready, mod_error, mod_res,
        output gnt, done, res, err, mod_go, mod_a, mod_b
    );

    modport master (
        output req, a, b, mod_ready, mod_error, mod_res,
        input  gnt, done, res, err, mod_go, mod_a, mod_b
    );
endinterface

// File: rtl/modulo_arbiter.sv
// Round-robin arbiter sharing one modulo unit among NREQ requesters.
// Latches the winner's operands, runs the go/ready handshake and returns the result with a done pulse.
module modulo_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input logic             clk,
    input logic             rst,
    modulo_arbiter_if.slave arb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_DLY = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    win_r;
    logic [PW-1:0]    idx_s;
    logic [PW-1:0]    pick_s;
    logic [PW-1:0]    next_ptr_s;
    logic             found_s;
    logic [WIDTH-1:0] pick_a_s;
    logic [WIDTH-1:0] pick_b_s;
    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  done_r;
    logic [WIDTH-1:0] res_r;
    logic             err_r;
    logic             go_r;
    logic [WIDTH-1:0] mod_a_r;
    logic [WIDTH-1:0] mod_b_r;

    function automatic logic [NREQ-1:0] one_hot(input logic [PW-1:0] idx);
        one_hot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign arb.gnt    = gnt_r;
    assign arb.done   = done_r;
    assign arb.res    = res_r;
    assign arb.err    = err_r;
    assign arb.mod_go = go_r;
    assign arb.mod_a  = mod_a_r;
    assign arb.mod_b  = mod_b_r;

    assign next_ptr_s = (win_r == PW'(NREQ - 1)) ? {PW{1'b0}} : win_r + PW'(1'b1);

    // Winner search: first requesting index at or after the pointer, wrapping around.
    always_comb begin
        found_s  = 1'b0;
        idx_s    = {PW{1'b0}};
        pick_s   = {PW{1'b0}};
        pick_a_s = {WIDTH{1'b0}};
        pick_b_s = {WIDTH{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = PW'((int'(ptr_r) + k) % NREQ);
            if (!found_s && arb.req[idx_s]) begin
                found_s  = 1'b1;
                pick_s   = idx_s;
                pick_a_s = arb.a[idx_s*WIDTH +: WIDTH];
                pick_b_s = arb.b[idx_s*WIDTH +: WIDTH];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Sequencer; ready is not looked at in WAIT_DLY because the unit still shows the previous op's level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            ptr_r   <= {PW{1'b0}};
            win_r   <= {PW{1'b0}};
            gnt_r   <= {NREQ{1'b0}};
            done_r  <= {NREQ{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            err_r   <= 1'b0;
            go_r    <= 1'b0;
            mod_a_r <= {WIDTH{1'b0}};
            mod_b_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= {NREQ{1'b0}};
                    if (found_s) begin
                        win_r   <= pick_s;
                        mod_a_r <= pick_a_s;
                        mod_b_r <= pick_b_s;
                        gnt_r   <= one_hot(pick_s);
                        go_r    <= 1'b1;
                        state_r <= S_ISSUE;
                    end else begin
                        gnt_r   <= {NREQ{1'b0}};
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    go_r    <= 1'b0;
                    state_r <= S_WAIT_DLY;
                end
                S_WAIT_DLY: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (arb.mod_error) begin
                        err_r   <= 1'b1;
                        res_r   <= {WIDTH{1'b0}};
                        done_r  <= one_hot(win_r);
                        state_r <= S_DONE;
                    end else if (arb.mod_ready) begin
                        err_r   <= 1'b0;
                        res_r   <= arb.mod_res;
                        done_r  <= one_hot(win_r);
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DONE: begin
                    done_r  <= {NREQ{1'b0}};
                    gnt_r   <= {NREQ{1'b0}};
                    ptr_r   <= next_ptr_s;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= {NREQ{1'b0}};
                    gnt_r   <= {NREQ{1'b0}};
                    go_r    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modulo_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model,
// with the bench acting as both the requesters and the modulo unit.
module tb_modulo_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    modulo_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
    modulo_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .arb(bus));

    int n_chk = 0;
    int n_fail = 0;

    // Model state: an operation is "in flight" for some number of cycles after it is granted.
    logic [NREQ-1:0]  e_gnt, e_done;
    logic [WIDTH-1:0] e_res, e_a, e_b;
    logic             e_err, e_go;
    int               m_ptr, m_w, m_age, m_pick;
    bit               m_busy;

    // Stub modulo unit and bookkeeping.
    int stub_age, stub_left, force_lat;
    bit stale_one, rand_en;
    logic [WIDTH-1:0] stub_res, go_a, go_b;
    logic stub_err;
    int served_q[$];
    int res_q[$];
    int err_q[$];
    int go_count, gnt_cycles;
    int waited[NREQ];
    logic [NREQ-1:0] last_gnt;

    function automatic int first_from(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always_comb m_pick = first_from(m_ptr, bus.req);

    // Transaction-level reference: grant next round-robin winner, finish on first error/ready seen
    // three or more cycles after the grant, then one cycle of done and back to idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_ptr <= 0; m_w <= 0; m_age <= 0;
            e_gnt <= '0; e_done <= '0; e_res <= '0; e_err <= 1'b0; e_go <= 1'b0; e_a <= '0; e_b <= '0;
        end else if (!m_busy) begin
            e_done <= '0;
            if (m_pick >= 0) begin
                m_busy <= 1'b1; m_age <= 1; m_w <= m_pick; e_go <= 1'b1;
                e_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << m_pick;
                e_a <= bus.a[m_pick*WIDTH +: WIDTH];
                e_b <= bus.b[m_pick*WIDTH +: WIDTH];
            end else begin
                e_gnt <= '0;
            end
        end else begin
            e_go <= 1'b0;
            m_age <= m_age + 1;
            if (e_done != '0) begin
                e_done <= '0; e_gnt <= '0; m_busy <= 1'b0; m_ptr <= (m_w + 1) % NREQ;
            end else if (m_age >= 3 && (bus.mod_error || bus.mod_ready)) begin
                e_done <= e_gnt;
                e_err  <= bus.mod_error;
                e_res  <= (bus.mod_error || e_b == '0) ? '0 : e_a % e_b;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic stale();
        bus.mod_ready = stale_one ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mod_error = stale_one ? 1'b0 : 1'($urandom_range(0, 1));
        bus.mod_res   = 16'($urandom);
    endtask

    task automatic raise(input int i, input int av, input int bv);
        bus.a[i*WIDTH +: WIDTH] = 16'(av);
        bus.b[i*WIDTH +: WIDTH] = 16'(bv);
        bus.req[i] = 1'b1;
        waited[i] = 0;
    endtask

    // One cycle: compare at the falling edge, then drive the modulo stub and the requesters.
    task automatic step();
        @(negedge clk);
        last_gnt = bus.gnt;
        if (!rst) begin
            chk("gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("mod_go", 32'(bus.mod_go), 32'(e_go));
            chk("mod_a", 32'(bus.mod_a), 32'(e_a));
            chk("mod_b", 32'(bus.mod_b), 32'(e_b));
            chk("res", 32'(bus.res), 32'(e_res));
            chk("err", 32'(bus.err), 32'(e_err));
            if (bus.mod_go) begin go_count++; go_a = bus.mod_a; go_b = bus.mod_b; end
            if (bus.gnt != '0) gnt_cycles++;
        end
        if (rst) begin
            bus.mod_ready = 1'b0; bus.mod_error = 1'b0; bus.mod_res = '0; stub_age = 0;
        end else if (bus.mod_go) begin
            stub_age  = 1;
            stub_err  = (bus.mod_b == '0);
            stub_res  = stub_err ? '0 : bus.mod_a % bus.mod_b;
            stub_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
            stale();
        end else if (stub_age == 1) begin
            stub_age = 2;
            stale();
        end else if (stub_age == 2) begin
            if (stub_left == 0) begin
                bus.mod_ready = 1'b1; bus.mod_error = stub_err;
                bus.mod_res = stub_err ? 16'($urandom) : stub_res;
                stub_age = 0;
            end else begin
                bus.mod_ready = 1'b0; bus.mod_error = 1'b0; stub_left--;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && bus.done[i]) begin
                served_q.push_back(i); res_q.push_back(int'(bus.res)); err_q.push_back(int'(bus.err));
                chk("fairness_wait", 32'(waited[i] <= NREQ - 1), 32'd1);
                for (int j = 0; j < NREQ; j++) if (j != i && bus.req[j]) waited[j]++;
                waited[i] = 0;
                bus.req[i] = 1'b0;
            end
        end
        if (rand_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i] && !bus.done[i]) begin
                    if ($urandom_range(0, 5) == 0) bus.a[i*WIDTH +: WIDTH] = 16'($urandom);
                    if (bus.req[i] && $urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i] && !bus.gnt[i] && $urandom_range(0, 3) == 0) begin
                    raise(i, int'($urandom_range(0, 65535)),
                          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300)));
                end
            end
        end
    endtask

    task automatic wait_serv(input int n, input int budget, output int steps);
        steps = 0;
        while (served_q.size() < n && steps < budget) begin
            step();
            steps++;
        end
        if (served_q.size() < n) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: %0d of %0d services after %0d cycles", served_q.size(), n, steps);
        end
    endtask

    task automatic clear_logs();
        served_q.delete(); res_q.delete(); err_q.delete();
        go_count = 0; gnt_cycles = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_go", 32'(bus.mod_go), 32'd0);
        chk("rst_mod_ab", 32'({bus.mod_a, bus.mod_b}), 32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;
        clear_logs();
    endtask

    initial begin
        int st;
        rst = 1'b1; bus.req = '0; bus.a = '0; bus.b = '0;
        bus.mod_ready = 1'b0; bus.mod_error = 1'b0; bus.mod_res = '0;
        force_lat = 0; stale_one = 1'b0; rand_en = 1'b0; stub_age = 0; stub_left = 0;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;
        do_reset();

        // Single requester, instant modulo: 17 mod 5.
        raise(0, 17, 5);
        wait_serv(1, 20, st);
        chk("t1_latency", 32'(st), 32'd4);
        chk("t1_go_pulses", 32'(go_count), 32'd1);
        chk("t1_go_ab", 32'({go_a, go_b}), {16'd17, 16'd5});
        chk("t1_gnt_cycles", 32'(gnt_cycles), 32'd4);
        chk("t1_res", 32'(q_at(res_q, 0)), 32'd2);
        chk("t1_err", 32'(q_at(err_q, 0)), 32'd0);
        step(); step();

        // All four at once after reset; requester 0 asks again right after its service.
        do_reset();
        for (int i = 0; i < NREQ; i++) raise(i, 100 + i, 7);
        wait_serv(1, 20, st);
        raise(0, 100, 7);
        wait_serv(5, 60, st);
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", 32'(q_at(served_q, i)), 32'(i % 4));
            chk("t2_res", 32'(q_at(res_q, i)), 32'(2 + (i % 4)));
        end
        step(); step();

        // Divide by zero on requester 2, then a normal op on requester 3.
        clear_logs();
        raise(2, 50, 0);
        wait_serv(1, 20, st);
        chk("t3_err", 32'(q_at(err_q, 0)), 32'd1);
        chk("t3_res", 32'(q_at(res_q, 0)), 32'd0);
        step();
        raise(3, 17, 5);
        wait_serv(2, 20, st);
        chk("t3_next_err", 32'(q_at(err_q, 1)), 32'd0);
        chk("t3_next_res", 32'(q_at(res_q, 1)), 32'd2);
        step(); step();

        // Stale ready through the delay slot, then ready low for 10 cycles.
        clear_logs();
        force_lat = 10; stale_one = 1'b1;
        raise(0, 33, 8);
        wait_serv(1, 40, st);
        chk("t5_latency", 32'(st), 32'd14);
        chk("t5_res", 32'(q_at(res_q, 0)), 32'd1);
        repeat (6) step();
        chk("t5_done_once", 32'(served_q.size()), 32'd1);
        force_lat = 0; stale_one = 1'b0;

        // Operand change two cycles after grant is ignored.
        clear_logs();
        raise(1, 17, 5);
        st = 0;
        while (!last_gnt[1] && st < 10) begin step(); st++; end
        step(); step();
        bus.a[1*WIDTH +: WIDTH] = 16'd20;
        wait_serv(1, 20, st);
        chk("t4_res", 32'(q_at(res_q, 0)), 32'd2);
        chk("t4_go_pulses", 32'(go_count), 32'd1);
        step(); step();

        // Reset during WAIT aborts the op; afterwards requester 0 goes first.
        clear_logs();
        force_lat = 6;
        raise(0, 9, 4);
        raise(2, 11, 4);
        st = 0;
        while (last_gnt == '0 && st < 10) begin step(); st++; end
        chk("t6_gnt_before", 32'(last_gnt), 32'h4);
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
        chk("t6_async_done", 32'(bus.done), 32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;
        wait_serv(1, 30, st);
        chk("t6_first_after_rst", 32'(q_at(served_q, 0)), 32'd0);
        chk("t6_res0", 32'(q_at(res_q, 0)), 32'd1);
        wait_serv(2, 30, st);
        chk("t6_second", 32'(q_at(served_q, 1)), 32'd2);
        chk("t6_res2", 32'(q_at(res_q, 1)), 32'd3);
        step(); step();

        // Randomized traffic.
        force_lat = -1;
        rand_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        st = 0;
        while ((bus.req != '0 || bus.gnt != '0) && st < 300) begin step(); st++; end
        chk("drain_idle", 32'({bus.req, bus.gnt}), 32'd0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
